// File: rtl/cache_def.sv
// Shared types and default sizes for the L1 instruction-side victim buffer.
// Revision: 1.0
`default_nettype none

package cache_def;

  localparam int VC_ENTRIES = 8;
  localparam int LINE_W     = 128;
  localparam int LADDR_W    = 28;

  typedef struct packed {
    logic               valid;
    logic [LADDR_W-1:0] laddr;
    logic [LINE_W-1:0]  data;
  } vc_entry_type;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } vc_state_type;

endpackage

`default_nettype wire

// File: rtl/vc_match.sv
// vc_match: combinational CAM compare of one address against all valid entries.
// Revision: 1.0
`default_nettype none

module vc_match #(
  parameter int NUM_ENTRIES = 8,
  parameter int LADDR_W     = 28
) (
  input  logic [NUM_ENTRIES-1:0]         valid_i,
  input  logic [LADDR_W-1:0]             laddr_i [NUM_ENTRIES],
  input  logic [LADDR_W-1:0]             addr_i,
  output logic [NUM_ENTRIES-1:0]         match_o,
  output logic                           hit_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cmp
    assign match_o[i] = valid_i[i] && (laddr_i[i] == addr_i);
  end

  assign hit_o = |match_o;

  // Entries never hold duplicates, so the vector is one-hot and a priority encode is exact.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match_o[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/victim_cache.sv
// victim_cache: fully-associative victim buffer answering L1 evict/swap lookups.
// Build option VC_STATS_EN adds the lookup/hit/miss counters. Revision: 1.0
`default_nettype none

module victim_cache #(
  parameter int NUM_ENTRIES = cache_def::VC_ENTRIES,
  parameter int LINE_W      = cache_def::LINE_W,
  parameter int LADDR_W     = cache_def::LADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               lookup_valid_i,
  input  logic [LADDR_W-1:0] lookup_addr_i,
  input  logic               evict_valid_i,
  input  logic [LADDR_W-1:0] evict_addr_i,
  input  logic [LINE_W-1:0]  evict_data_i,
  output logic               resp_valid_o,
  output logic               vc_miss_o,
  output logic [LINE_W-1:0]  swap_data_o,
  output logic               accessing_o,
  output logic [31:0]        no_acc_o,
  output logic [31:0]        no_hit_o,
  output logic [31:0]        no_miss_o
);

  import cache_def::*;

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  vc_state_type            state_q, state_d;
  logic [NUM_ENTRIES-1:0]  valid_q, valid_d;
  logic [LADDR_W-1:0]      laddr_q [NUM_ENTRIES];
  logic [LADDR_W-1:0]      laddr_d [NUM_ENTRIES];
  logic [LINE_W-1:0]       data_q  [NUM_ENTRIES];
  logic [LINE_W-1:0]       data_d  [NUM_ENTRIES];
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    hit_q, hit_d;
  logic [NUM_ENTRIES-1:0]  match_q, match_d;
  logic [IDX_W-1:0]        hit_idx_q, hit_idx_d;
  logic [LINE_W-1:0]       resp_data_q, resp_data_d;

  logic [NUM_ENTRIES-1:0]  lk_match, ev_match, free_vec, free_oh, wr_oh;
  logic                    lk_hit, ev_hit, in_resp;
  logic [IDX_W-1:0]        lk_idx, ev_idx, free_idx, wr_idx;

  vc_match #(.NUM_ENTRIES(NUM_ENTRIES), .LADDR_W(LADDR_W)) u_lookup_match (
    .valid_i (valid_q),
    .laddr_i (laddr_q),
    .addr_i  (lookup_addr_i),
    .match_o (lk_match),
    .hit_o   (lk_hit),
    .idx_o   (lk_idx)
  );

  vc_match #(.NUM_ENTRIES(NUM_ENTRIES), .LADDR_W(LADDR_W)) u_evict_match (
    .valid_i (valid_q),
    .laddr_i (laddr_q),
    .addr_i  (evict_addr_i),
    .match_o (ev_match),
    .hit_o   (ev_hit),
    .idx_o   (ev_idx)
  );

  assign in_resp  = (state_q == RESP);
  assign free_vec = ~valid_q;
  assign free_oh  = free_vec & (~free_vec + NUM_ENTRIES'(1));

  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    laddr_d     = laddr_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    hit_d       = hit_q;
    match_d     = match_q;
    hit_idx_d   = hit_idx_q;
    resp_data_d = resp_data_q;
    wr_idx      = '0;
    wr_oh       = '0;

    case (state_q)
      IDLE: begin
        if (lookup_valid_i) begin
          state_d     = RESP;
          hit_d       = lk_hit;
          match_d     = lk_match;
          hit_idx_d   = lk_idx;
          resp_data_d = lk_hit ? data_q[lk_idx] : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        // The hit line moves back to L1; match_q is all-zero on a miss.
        valid_d = valid_q & ~match_q;
      end
      default: state_d = IDLE;
    endcase

    // Evict slot priority: duplicate address, swap into hit slot, lowest free, round-robin.
    if (evict_valid_i) begin
      if (ev_hit) begin
        wr_idx = ev_idx;
        wr_oh  = ev_match;
      end else if (in_resp && hit_q) begin
        wr_idx = hit_idx_q;
        wr_oh  = match_q;
      end else if (|free_vec) begin
        wr_idx = free_idx;
        wr_oh  = free_oh;
      end else begin
        wr_idx   = rr_ptr_q;
        wr_oh    = NUM_ENTRIES'(1) << rr_ptr_q;
        rr_ptr_d = rr_ptr_q + IDX_W'(1);
      end
      valid_d         = valid_d | wr_oh;
      laddr_d[wr_idx] = evict_addr_i;
      data_d[wr_idx]  = evict_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      rr_ptr_q    <= '0;
      hit_q       <= 1'b0;
      match_q     <= '0;
      hit_idx_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rr_ptr_q    <= rr_ptr_d;
      hit_q       <= hit_d;
      match_q     <= match_d;
      hit_idx_q   <= hit_idx_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Payload storage is qualified by valid_q and needs no reset.
  always_ff @(posedge clk_i) begin
    laddr_q <= laddr_d;
    data_q  <= data_d;
  end

  assign resp_valid_o = in_resp;
  assign accessing_o  = in_resp;
  assign vc_miss_o    = in_resp && !hit_q;
  assign swap_data_o  = in_resp ? resp_data_q : '0;

`ifdef VC_STATS_EN
  logic [31:0] acc_q, acc_d, hits_q, hits_d, miss_q, miss_d;

  always_comb begin
    acc_d  = acc_q;
    hits_d = hits_q;
    miss_d = miss_q;
    if (in_resp) begin
      acc_d = acc_q + 32'd1;
      if (hit_q) hits_d = hits_q + 32'd1;
      else       miss_d = miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      hits_q <= '0;
      miss_q <= '0;
    end else begin
      acc_q  <= acc_d;
      hits_q <= hits_d;
      miss_q <= miss_d;
    end
  end

  assign no_acc_o  = acc_q;
  assign no_hit_o  = hits_q;
  assign no_miss_o = miss_q;
`else
  assign no_acc_o  = 32'd0;
  assign no_hit_o  = 32'd0;
  assign no_miss_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_victim_cache.sv
// Directed self-checking bench for victim_cache.
// Revision: 1.0
`default_nettype none

module tb_victim_cache;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         lookup_valid_i = 1'b0;
  logic [27:0]  lookup_addr_i = '0;
  logic         evict_valid_i = 1'b0;
  logic [27:0]  evict_addr_i = '0;
  logic [127:0] evict_data_i = '0;
  logic         resp_valid_o, vc_miss_o, accessing_o;
  logic [127:0] swap_data_o;
  logic [31:0]  no_acc_o, no_hit_o, no_miss_o;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_hit = 0;
  int n_miss = 0;

  victim_cache dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .lookup_valid_i (lookup_valid_i),
    .lookup_addr_i  (lookup_addr_i),
    .evict_valid_i  (evict_valid_i),
    .evict_addr_i   (evict_addr_i),
    .evict_data_i   (evict_data_i),
    .resp_valid_o   (resp_valid_o),
    .vc_miss_o      (vc_miss_o),
    .swap_data_o    (swap_data_o),
    .accessing_o    (accessing_o),
    .no_acc_o       (no_acc_o),
    .no_hit_o       (no_hit_o),
    .no_miss_o      (no_miss_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [27:0] a);
    return {4{4'hC, a}};
  endfunction

  function automatic logic [31:0] cnt(input int v);
`ifdef VC_STATS_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_acc"},  {96'd0, no_acc_o},  {96'd0, cnt(n_acc)});
    chk({tag, "_hit"},  {96'd0, no_hit_o},  {96'd0, cnt(n_hit)});
    chk({tag, "_miss"}, {96'd0, no_miss_o}, {96'd0, cnt(n_miss)});
  endtask

  task automatic evict(input logic [27:0] a, input logic [127:0] d);
    evict_valid_i = 1'b1;
    evict_addr_i  = a;
    evict_data_i  = d;
    tick();
    evict_valid_i = 1'b0;
  endtask

  // Lookup; optionally present an eviction during the response cycle.
  task automatic lookup(input string tag, input logic [27:0] a, input logic exp_miss,
                        input logic [127:0] exp_data, input logic resp_ev,
                        input logic [27:0] ev_a, input logic [127:0] ev_d);
    lookup_valid_i = 1'b1;
    lookup_addr_i  = a;
    tick();
    lookup_valid_i = 1'b0;
    if (resp_ev) begin
      evict_valid_i = 1'b1;
      evict_addr_i  = ev_a;
      evict_data_i  = ev_d;
    end
    chk({tag, "_resp_valid"}, {127'd0, resp_valid_o}, 128'd1);
    chk({tag, "_accessing"},  {127'd0, accessing_o},  128'd1);
    chk({tag, "_vc_miss"},    {127'd0, vc_miss_o},    {127'd0, exp_miss});
    chk({tag, "_swap_data"},  swap_data_o,            exp_data);
    tick();
    evict_valid_i = 1'b0;
    chk({tag, "_resp_clear"}, {127'd0, resp_valid_o}, 128'd0);
    n_acc++;
    if (exp_miss) n_miss++;
    else          n_hit++;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_resp_valid", {127'd0, resp_valid_o}, 128'd0);
    chk("rst_vc_miss",    {127'd0, vc_miss_o},    128'd0);
    chk("rst_accessing",  {127'd0, accessing_o},  128'd0);
    chk("rst_swap_data",  swap_data_o,            128'd0);
    chk_counters("rst");
    tick();
    rst_ni = 1'b1;
    tick();

    // Cold miss
    lookup("cold", 28'h0000100, 1'b1, 128'd0, 1'b0, 28'd0, 128'd0);
    chk_counters("cold");

    // Evict then hit; hit entry is invalidated
    evict(28'h0000100, {16{8'hA5}});
    lookup("a5_hit",  28'h0000100, 1'b0, {16{8'hA5}}, 1'b0, 28'd0, 128'd0);
    lookup("a5_gone", 28'h0000100, 1'b1, 128'd0,      1'b0, 28'd0, 128'd0);
    chk_counters("a5");

    // Fill all 8 slots, then one more replaces slot 0 and advances rr_ptr to 1
    for (int i = 0; i < 8; i++) evict(28'h10 + 28'(i), line_of(28'h10 + 28'(i)));
    evict(28'h18, line_of(28'h18));
    lookup("rr_10_gone", 28'h10, 1'b1, 128'd0,          1'b0, 28'd0, 128'd0);
    lookup("rr_11_hit",  28'h11, 1'b0, line_of(28'h11), 1'b0, 28'd0, 128'd0);

    // True swap: eviction during a hit response lands in the hit slot
    lookup("swap_12",    28'h12, 1'b0, line_of(28'h12), 1'b1, 28'h99, line_of(28'h99));
    lookup("swap_99",    28'h99, 1'b0, line_of(28'h99), 1'b0, 28'd0, 128'd0);
    lookup("swap_12_gone", 28'h12, 1'b1, 128'd0,        1'b0, 28'd0, 128'd0);

    // Duplicate eviction overwrites the existing entry
    evict(28'h20, {4{32'hD1D1D1D1}});
    evict(28'h20, {4{32'hD2D2D2D2}});
    lookup("dup_d2",   28'h20, 1'b0, {4{32'hD2D2D2D2}}, 1'b0, 28'd0, 128'd0);
    lookup("dup_gone", 28'h20, 1'b1, 128'd0,            1'b0, 28'd0, 128'd0);

    // Slots 1 and 2 free: refill, then replacement uses rr_ptr=1 (slot 0 survives)
    evict(28'h30, line_of(28'h30));
    evict(28'h31, line_of(28'h31));
    evict(28'h32, line_of(28'h32));
    lookup("rr2_30_gone", 28'h30, 1'b1, 128'd0,          1'b0, 28'd0, 128'd0);
    lookup("rr2_31_hit",  28'h31, 1'b0, line_of(28'h31), 1'b0, 28'd0, 128'd0);
    lookup("rr2_18_hit",  28'h18, 1'b0, line_of(28'h18), 1'b0, 28'd0, 128'd0);

    // Same-cycle evict and lookup of one address: lookup sees pre-write contents
    evict_valid_i  = 1'b1;
    evict_addr_i   = 28'h40;
    evict_data_i   = line_of(28'h40);
    lookup("same_cyc_miss", 28'h40, 1'b1, 128'd0,          1'b0, 28'd0, 128'd0);
    lookup("same_cyc_hit",  28'h40, 1'b0, line_of(28'h40), 1'b0, 28'd0, 128'd0);
    chk_counters("mid");

    // Reset during the response cycle
    evict(28'h50, line_of(28'h50));
    lookup_valid_i = 1'b1;
    lookup_addr_i  = 28'h50;
    tick();
    lookup_valid_i = 1'b0;
    chk("prerst_resp_valid", {127'd0, resp_valid_o}, 128'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_resp_valid", {127'd0, resp_valid_o}, 128'd0);
    chk("midrst_swap_data",  swap_data_o,            128'd0);
    n_acc = 0;
    n_hit = 0;
    n_miss = 0;
    chk_counters("midrst");
    tick();
    rst_ni = 1'b1;
    tick();
    lookup("postrst_50", 28'h50, 1'b1, 128'd0, 1'b0, 28'd0, 128'd0);
    chk_counters("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
